// File: rtl/powerup_scheduler.sv
// powerup_scheduler
//   Schedules timed present drops toward the present spawner and converts
//   present-collection events into timed power-up effect flags. Every piece
//   of game-visible state is held clear outside the play state. The LFSR is
//   the exception: it free-runs so that drop contents stay unpredictable.
//
// Ports
//   clk          in   system clock
//   resetN       in   asynchronous, active-low reset
//   gameState    in   0 welcome, 1 play, 2 game over
//   secClk       in   one-cycle pulse per second
//   collect      in   one-cycle pulse: a present was collected
//   collectType  in   type of the collected present (valid with collect)
//   ropeBallHit  in   rope hit a ball; cancels super rope
//   dropAck      in   spawner accepted the current drop
//   dropReq      out  drop request, held until acknowledged
//   dropType     out  present type, stable while dropReq is high
//   dropX        out  present X position, stable while dropReq is high
//   extraLife    out  one-cycle pulse: add a life
//   superRope    out  super-rope effect active
//   superSpeed   out  super-speed effect active
//   immortal     out  immortality effect active
module powerup_scheduler #(
  parameter int          DROP_PERIOD    = 3,
  parameter int          SUPER_ROPE_SEC = 5,
  parameter int          SPEED_SEC      = 8,
  parameter int          IMMORTAL_SEC   = 5,
  parameter int          X_MIN          = 32,
  parameter int          X_MAX          = 607,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [1:0]  gameState,
  input  logic        secClk,
  input  logic        collect,
  input  logic [1:0]  collectType,
  input  logic        ropeBallHit,
  input  logic        dropAck,
  output logic        dropReq,
  output logic [1:0]  dropType,
  output logic [10:0] dropX,
  output logic        extraLife,
  output logic        superRope,
  output logic        superSpeed,
  output logic        immortal
);

  localparam logic [1:0] PLAY = 2'd1;

  // Bit 0 of the encoding is the request flag itself, so dropReq comes
  // straight off a flop. RELEASE holds the request one more cycle after the
  // ack is sampled, before the handshake returns to IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    RELEASE = 2'b11
  } dropState_t;

  dropState_t  state, stateNext;
  logic [15:0] lfsr, lfsrNext;
  logic [3:0]  secCnt, secCntNext;
  logic [3:0]  ropeTimer, ropeTimerNext;
  logic [3:0]  speedTimer, speedTimerNext;
  logic [3:0]  immortalTimer, immortalTimerNext;
  logic [1:0]  dropTypeNext;
  logic [10:0] dropXNext;
  logic        extraLifeNext;
  logic        fire;
  logic [10:0] xDirect, xFolded;

  // 10-bit raw position; fold it in half when it would overshoot X_MAX.
  assign xDirect = 11'(X_MIN) + 11'(lfsr[14:5]);
  assign xFolded = 11'(X_MIN) + 11'(lfsr[14:6]);
  assign fire    = secClk && (secCnt == 4'(DROP_PERIOD - 1));
  assign dropReq = state[0];

  // Load beats decrement; a timer that has reached zero stays at zero.
  function automatic logic [3:0] nextTimer(input logic [3:0] t, input logic load,
                                           input logic [3:0] dur, input logic dec);
    if (load)             return dur;
    else if (dec && t != 4'd0) return t - 4'd1;
    else                  return t;
  endfunction

  always_comb begin
    // NOTE: every variable is given a default before any branch, so no path
    // leaves a value unassigned and no latch can be inferred.
    lfsrNext          = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    stateNext         = state;
    secCntNext        = secCnt;
    dropTypeNext      = dropType;
    dropXNext         = dropX;
    extraLifeNext     = 1'b0;
    ropeTimerNext     = ropeTimer;
    speedTimerNext    = speedTimer;
    immortalTimerNext = immortalTimer;

    if (gameState != PLAY) begin
      stateNext         = IDLE;
      secCntNext        = 4'd0;
      dropTypeNext      = 2'd0;
      dropXNext         = 11'd0;
      ropeTimerNext     = 4'd0;
      speedTimerNext    = 4'd0;
      immortalTimerNext = 4'd0;
    end else begin
      if (fire)        secCntNext = 4'd0;
      else if (secClk) secCntNext = secCnt + 4'd1;

      unique case (state)
        IDLE: if (fire) begin
          dropTypeNext = lfsr[1:0];
          dropXNext    = (xDirect <= 11'(X_MAX)) ? xDirect : xFolded;
          stateNext    = PENDING;
        end
        // A firing attempt while a request is outstanding is simply lost.
        PENDING: if (dropAck) stateNext = RELEASE;
        RELEASE: stateNext = IDLE;
        default: stateNext = IDLE;
      endcase

      extraLifeNext = collect && (collectType == 2'b00);

      // A rope reload outranks a ball hit in the same cycle.
      if (collect && collectType == 2'b01) ropeTimerNext = 4'(SUPER_ROPE_SEC);
      else if (ropeBallHit)                ropeTimerNext = 4'd0;
      else ropeTimerNext = nextTimer(ropeTimer, 1'b0, 4'd0, secClk);

      speedTimerNext    = nextTimer(speedTimer, collect && collectType == 2'b10,
                                    4'(SPEED_SEC), secClk);
      immortalTimerNext = nextTimer(immortalTimer, collect && collectType == 2'b11,
                                    4'(IMMORTAL_SEC), secClk);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= IDLE;
      lfsr          <= LFSR_SEED;
      secCnt        <= 4'd0;
      dropType      <= 2'd0;
      dropX         <= 11'd0;
      extraLife     <= 1'b0;
      ropeTimer     <= 4'd0;
      speedTimer    <= 4'd0;
      immortalTimer <= 4'd0;
      superRope     <= 1'b0;
      superSpeed    <= 1'b0;
      immortal      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values present before the edge, independent of statement order.
      state         <= stateNext;
      lfsr          <= lfsrNext;
      secCnt        <= secCntNext;
      dropType      <= dropTypeNext;
      dropX         <= dropXNext;
      extraLife     <= extraLifeNext;
      ropeTimer     <= ropeTimerNext;
      speedTimer    <= speedTimerNext;
      immortalTimer <= immortalTimerNext;
      // Flags are registered from the next timer values so they move on the
      // same edge as the timers instead of being decoded after them.
      superRope     <= (ropeTimerNext != 4'd0);
      superSpeed    <= (speedTimerNext != 4'd0);
      immortal      <= (immortalTimerNext != 4'd0);
    end
  end

endmodule

// File: tb/tb_powerup_scheduler.sv
// tb_powerup_scheduler
//   Directed bench for powerup_scheduler. Expected drop contents are pushed
//   to a queue from an independent LFSR model when the firing secClk is
//   driven, and popped when dropReq rises.
module tb_powerup_scheduler;

  logic        clk = 1'b0;
  logic        resetN;
  logic [1:0]  gameState;
  logic        secClk;
  logic        collect;
  logic [1:0]  collectType;
  logic        ropeBallHit;
  logic        dropAck;
  logic        dropReq;
  logic [1:0]  dropType;
  logic [10:0] dropX;
  logic        extraLife;
  logic        superRope;
  logic        superSpeed;
  logic        immortal;

  always #5 clk = ~clk;

  powerup_scheduler #(
    .DROP_PERIOD(3), .SUPER_ROPE_SEC(5), .SPEED_SEC(8), .IMMORTAL_SEC(5),
    .X_MIN(32), .X_MAX(607), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .resetN(resetN), .gameState(gameState), .secClk(secClk),
    .collect(collect), .collectType(collectType), .ropeBallHit(ropeBallHit),
    .dropAck(dropAck), .dropReq(dropReq), .dropType(dropType), .dropX(dropX),
    .extraLife(extraLife), .superRope(superRope), .superSpeed(superSpeed),
    .immortal(immortal)
  );

  // Reference LFSR: x^16+x^14+x^13+x^11+1, shifting every clock.
  logic [15:0] mLfsr;
  always @(posedge clk or negedge resetN)
    if (!resetN) mLfsr <= 16'hACE1;
    else         mLfsr <= {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};

  typedef struct packed {
    logic [1:0]  t;
    logic [10:0] x;
  } drop_t;

  drop_t sb[$];
  drop_t lastExp;
  int    total  = 0;
  int    passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sec();
    secClk = 1'b1;
    tick();
    secClk = 1'b0;
  endtask

  // Called just before the firing secClk is driven: mLfsr now holds the
  // value the DUT will sample on that edge.
  task automatic expectDrop();
    drop_t     e;
    logic [9:0] raw;
    int        sum;
    raw = mLfsr[14:5];
    sum = 32 + int'(raw);
    e.t = mLfsr[1:0];
    e.x = (sum <= 607) ? 11'(sum) : 11'(32 + int'(raw >> 1));
    sb.push_back(e);
  endtask

  task automatic checkDrop(input string tag);
    check({tag, "_req"}, 32'(dropReq), 32'd1);
    check({tag, "_sbDepth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      lastExp = sb.pop_front();
      check({tag, "_type"}, 32'(dropType), 32'(lastExp.t));
      check({tag, "_x"}, 32'(dropX), 32'(lastExp.x));
      check({tag, "_xRange"}, 32'(dropX >= 11'd32 && dropX <= 11'd607), 32'd1);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_outs"},
          32'({dropReq, dropType, dropX, extraLife, superRope, superSpeed, immortal}),
          32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    resetN = 1'b0; gameState = 2'd0; secClk = 1'b0; collect = 1'b0;
    collectType = 2'd0; ropeBallHit = 1'b0; dropAck = 1'b0;
    tick(2);
    checkAllZero("reset");
    resetN = 1'b1;
    gameState = 2'd1;
    tick();
    checkAllZero("playIdle");

    // Ack tied high: a drop every third second, request high two cycles.
    dropAck = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sec(); tick(); sec(); tick();
      check("ackHigh_preFire", 32'(dropReq), 32'd0);
      expectDrop();
      sec();
      checkDrop("ackHigh");
      tick();
      check("ackHigh_cycle2", 32'(dropReq), 32'd1);
      tick();
      check("ackHigh_cleared", 32'(dropReq), 32'd0);
    end

    // Ack held low across seven seconds: one request persists unchanged.
    dropAck = 1'b0;
    sec(); tick(); sec(); tick();
    expectDrop();
    sec();
    checkDrop("ackLow");
    for (int k = 4; k <= 7; k++) begin
      sec(); tick();
      check("ackLow_held", 32'(dropReq), 32'd1);
      check("ackLow_type", 32'(dropType), 32'(lastExp.t));
      check("ackLow_x", 32'(dropX), 32'(lastExp.x));
    end
    dropAck = 1'b1;
    tick();
    dropAck = 1'b0;
    check("ackLow_release", 32'(dropReq), 32'd1);
    tick();
    check("ackLow_cleared", 32'(dropReq), 32'd0);
    sec(); tick();
    check("sec8_noDrop", 32'(dropReq), 32'd0);
    expectDrop();
    sec();
    checkDrop("sec9");
    dropAck = 1'b1;
    tick(2);
    check("sec9_cleared", 32'(dropReq), 32'd0);

    // Immortal: five seconds, then a reload on the same cycle as a secClk.
    collect = 1'b1; collectType = 2'b11;
    tick();
    collect = 1'b0;
    check("imm_rise", 32'(immortal), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      sec(); tick();
      check("imm_hold", 32'(immortal), 32'd1);
    end
    sec();
    check("imm_fall", 32'(immortal), 32'd0);
    collect = 1'b1;
    tick();
    collect = 1'b0;
    sec(); sec();
    collect = 1'b1;
    sec();
    collect = 1'b0;
    check("imm_reload", 32'(immortal), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      sec();
      check("imm_reloadHold", 32'(immortal), 32'd1);
    end
    sec();
    check("imm_reloadFall", 32'(immortal), 32'd0);

    // Super rope: load wins over a simultaneous ball hit; later hit cancels.
    collect = 1'b1; collectType = 2'b01; ropeBallHit = 1'b1;
    tick();
    collect = 1'b0; ropeBallHit = 1'b0;
    check("rope_loadBeatsHit", 32'(superRope), 32'd1);
    tick(2);
    check("rope_hold", 32'(superRope), 32'd1);
    ropeBallHit = 1'b1;
    tick();
    ropeBallHit = 1'b0;
    check("rope_cancel", 32'(superRope), 32'd0);
    collect = 1'b1; collectType = 2'b00;
    tick();
    collect = 1'b0;
    check("life_pulse", 32'({extraLife, superSpeed, immortal}), 32'b100);
    tick();
    check("life_end", 32'(extraLife), 32'd0);

    // Leaving play with a drop pending and speed active clears everything.
    gameState = 2'd0;
    tick();
    gameState = 2'd1;
    dropAck = 1'b0;
    collect = 1'b1; collectType = 2'b10;
    tick();
    collect = 1'b0;
    check("speed_rise", 32'(superSpeed), 32'd1);
    sec(); tick(); sec(); tick();
    expectDrop();
    sec();
    checkDrop("gate_pre");
    check("speed_running", 32'(superSpeed), 32'd1);
    gameState = 2'd2;
    tick();
    checkAllZero("gate_over");
    sec(); sec();
    checkAllZero("gate_overSec");
    gameState = 2'd1;
    sec(); tick(); sec(); tick();
    check("gate_replay_noDrop", 32'(dropReq), 32'd0);
    expectDrop();
    sec();
    checkDrop("gate_replay");

    // Reset mid-handshake: outputs clear at once, LFSR restarts at the seed.
    collect = 1'b1; collectType = 2'b11;
    tick();
    collect = 1'b0;
    check("rst_pre", 32'({dropReq, immortal}), 32'b11);
    resetN = 1'b0;
    #2;
    checkAllZero("rst_async");
    @(posedge clk);
    #1;
    resetN = 1'b1;
    sec(); tick(); sec(); tick();
    check("rst_noDrop", 32'(dropReq), 32'd0);
    expectDrop();
    sec();
    checkDrop("rst_first");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
